// File: rtl/can_frame_rx.sv
// CAN 2.0 frame receiver: oversampled bit timing, destuffing, CRC-15 check and field capture.
// Extended (29-bit) identifiers are decoded only when CAN_FRAME_RX_EXT_ID_EN is defined.
module can_frame_rx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int SAMPLE_CLK   = CLKS_PER_BIT / 2
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic        i_Rx_Serial,
    output logic        o_Rx_DV,
    output logic [28:0] o_Rx_Id,
    output logic        o_Rx_Ext,
    output logic        o_Rx_Rtr,
    output logic [3:0]  o_Rx_Dlc,
    output logic [63:0] o_Rx_Data,
    output logic        o_Rx_Err,
    output logic [1:0]  o_Rx_Err_Code
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [1:0] ERR_STUFF = 2'd0;
    localparam logic [1:0] ERR_FORM  = 2'd1;
    localparam logic [1:0] ERR_CRC   = 2'd2;

    typedef enum logic [3:0] {
        WAIT_IDLE, IDLE, ARB, CTRL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF
    } state_t;

    state_t        state_r, state_nxt_s;
    logic          sync1_r, sync2_r, prev_r;
    logic [CW-1:0] cnt_r;
    logic [6:0]    fld_cnt_r;
    logic [2:0]    stuff_cnt_r, stuff_nxt_s;
    logic          last_r;
    logic [14:0]   crc_r, rx_crc_r;
    logic [28:0]   id_r;
    logic          rtr_r;
    logic [3:0]    dlc_r, dlc_nxt_s;
    logic [63:0]   data_r;
    logic [6:0]    data_last_s;
    logic [5:0]    data_idx_s;
    logic          rx_s, edge_s, samp_s, stuffing_s, stuff_bit_s;
    logic          err_s, dv_s, fld_clr_s;
    logic [1:0]    err_code_s;
`ifdef CAN_FRAME_RX_EXT_ID_EN
    logic          ext_r;
`endif

    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[14];
        crc15_step = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    function automatic logic [3:0] byte_count(input logic rtr, input logic [3:0] dlc);
        if (rtr) begin
            byte_count = 4'd0;
        end else if (dlc > 4'd8) begin
            byte_count = 4'd8;
        end else begin
            byte_count = dlc;
        end
    endfunction

    assign rx_s        = sync2_r;
    assign edge_s      = (state_r == IDLE) && prev_r && !rx_s;
    assign samp_s      = (cnt_r == CW'(SAMPLE_CLK)) && !edge_s;
    assign stuffing_s  = (state_r == ARB) || (state_r == CTRL) || (state_r == DATA) || (state_r == CRC);
    assign stuff_bit_s = stuffing_s && (stuff_cnt_r == 3'd5);
    assign stuff_nxt_s = (rx_s == last_r) ? stuff_cnt_r + 3'd1 : 3'd1;
    assign dlc_nxt_s   = {dlc_r[2:0], rx_s};
    assign data_last_s = {byte_count(rtr_r, dlc_r), 3'b000} - 7'd1;
    assign data_idx_s  = 6'd63 - fld_cnt_r[5:0];

    // bus synchroniser and bit-time counter (restarts only on the SOF edge)
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
            cnt_r   <= '0;
        end else begin
            sync1_r <= i_Rx_Serial;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            if (edge_s || cnt_r == CW'(CLKS_PER_BIT - 1)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // state register and per-field bit counter
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r   <= WAIT_IDLE;
            fld_cnt_r <= 7'd0;
        end else begin
            state_r <= state_nxt_s;
            if (samp_s && fld_clr_s) begin
                fld_cnt_r <= 7'd0;
            end else if (samp_s && !stuff_bit_s) begin
                fld_cnt_r <= fld_cnt_r + 7'd1;
            end else begin
                fld_cnt_r <= fld_cnt_r;
            end
        end
    end

    // next-state decode, error classification and frame-valid strobe
    always_comb begin
        state_nxt_s = state_r;
        err_s       = 1'b0;
        err_code_s  = ERR_STUFF;
        dv_s        = 1'b0;
        if (samp_s && stuff_bit_s) begin
            if (rx_s == last_r) begin
                err_s = 1'b1; err_code_s = ERR_STUFF; state_nxt_s = WAIT_IDLE;
            end else if (state_r == CRC && fld_cnt_r == 7'd15) begin
                state_nxt_s = CRC_DEL;
            end else begin
                state_nxt_s = state_r;
            end
        end else if (samp_s) begin
            case (state_r)
                WAIT_IDLE: state_nxt_s = (rx_s && fld_cnt_r == 7'd10) ? IDLE : WAIT_IDLE;
                IDLE:      state_nxt_s = rx_s ? IDLE : ARB;
                ARB: begin
                    if (fld_cnt_r == 7'd12 && rx_s) begin
`ifdef CAN_FRAME_RX_EXT_ID_EN
                        state_nxt_s = ARB;
`else
                        err_s = 1'b1; err_code_s = ERR_FORM; state_nxt_s = WAIT_IDLE;
`endif
                    end else if (fld_cnt_r == 7'd12 || fld_cnt_r == 7'd32) begin
                        state_nxt_s = CTRL;
                    end else begin
                        state_nxt_s = ARB;
                    end
                end
                CTRL: begin
                    if (fld_cnt_r == 7'd4) begin
                        state_nxt_s = (byte_count(rtr_r, dlc_nxt_s) == 4'd0) ? CRC : DATA;
                    end else begin
                        state_nxt_s = CTRL;
                    end
                end
                DATA: state_nxt_s = (fld_cnt_r == data_last_s) ? CRC : DATA;
                // a stuff bit may still follow the last CRC bit
                CRC: begin
                    if (fld_cnt_r == 7'd14) begin
                        state_nxt_s = (stuff_nxt_s == 3'd5) ? CRC : CRC_DEL;
                    end else begin
                        state_nxt_s = CRC;
                    end
                end
                CRC_DEL: begin
                    if (!rx_s) begin
                        err_s = 1'b1; err_code_s = ERR_FORM; state_nxt_s = WAIT_IDLE;
                    end else begin
                        state_nxt_s = ACK;
                    end
                end
                ACK: state_nxt_s = ACK_DEL;
                ACK_DEL: begin
                    if (crc_r != rx_crc_r) begin
                        err_s = 1'b1; err_code_s = ERR_CRC; state_nxt_s = WAIT_IDLE;
                    end else if (!rx_s) begin
                        err_s = 1'b1; err_code_s = ERR_FORM; state_nxt_s = WAIT_IDLE;
                    end else begin
                        state_nxt_s = EOF;
                    end
                end
                EOF: begin
                    if (!rx_s) begin
                        err_s = 1'b1; err_code_s = ERR_FORM; state_nxt_s = WAIT_IDLE;
                    end else if (fld_cnt_r == 7'd6) begin
                        dv_s = 1'b1; state_nxt_s = WAIT_IDLE;
                    end else begin
                        state_nxt_s = EOF;
                    end
                end
                default: state_nxt_s = WAIT_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
        fld_clr_s = (state_nxt_s != state_r) || (state_r == WAIT_IDLE && !rx_s);
    end

    // destuff run tracking, CRC accumulation and field capture
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            stuff_cnt_r <= 3'd0; last_r <= 1'b1;
            crc_r <= 15'd0; rx_crc_r <= 15'd0;
            id_r <= 29'd0; rtr_r <= 1'b0; dlc_r <= 4'd0; data_r <= 64'd0;
`ifdef CAN_FRAME_RX_EXT_ID_EN
            ext_r <= 1'b0;
`endif
        end else if (samp_s && state_r == IDLE) begin
            stuff_cnt_r <= 3'd1; last_r <= 1'b0;
            crc_r <= 15'd0; rx_crc_r <= 15'd0;
            id_r <= 29'd0; rtr_r <= 1'b0; dlc_r <= 4'd0; data_r <= 64'd0;
`ifdef CAN_FRAME_RX_EXT_ID_EN
            ext_r <= 1'b0;
`endif
        end else if (samp_s && stuff_bit_s) begin
            stuff_cnt_r <= 3'd1; last_r <= rx_s;
        end else if (samp_s && stuffing_s) begin
            stuff_cnt_r <= stuff_nxt_s; last_r <= rx_s;
            case (state_r)
                ARB: begin
                    crc_r <= crc15_step(crc_r, rx_s);
                    if (fld_cnt_r <= 7'd10 || (fld_cnt_r >= 7'd13 && fld_cnt_r <= 7'd30)) begin
                        id_r <= {id_r[27:0], rx_s};
                    end
                    if (fld_cnt_r == 7'd11 || fld_cnt_r == 7'd31) begin
                        rtr_r <= rx_s;
                    end
`ifdef CAN_FRAME_RX_EXT_ID_EN
                    if (fld_cnt_r == 7'd12) begin
                        ext_r <= rx_s;
                    end
`endif
                end
                CTRL: begin
                    crc_r <= crc15_step(crc_r, rx_s);
                    if (fld_cnt_r != 7'd0) begin
                        dlc_r <= dlc_nxt_s;
                    end
                end
                DATA: begin
                    crc_r <= crc15_step(crc_r, rx_s);
                    data_r[data_idx_s] <= rx_s;
                end
                CRC: begin
                    if (fld_cnt_r < 7'd15) begin
                        rx_crc_r <= {rx_crc_r[13:0], rx_s};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // registered result strobes and field outputs (fields load only with DV)
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Rx_DV <= 1'b0; o_Rx_Err <= 1'b0; o_Rx_Err_Code <= 2'd0;
            o_Rx_Id <= 29'd0; o_Rx_Rtr <= 1'b0; o_Rx_Dlc <= 4'd0; o_Rx_Data <= 64'd0;
        end else begin
            o_Rx_DV  <= dv_s;
            o_Rx_Err <= err_s;
            if (err_s) begin
                o_Rx_Err_Code <= err_code_s;
            end
            if (dv_s) begin
                o_Rx_Id <= id_r; o_Rx_Rtr <= rtr_r; o_Rx_Dlc <= dlc_r; o_Rx_Data <= data_r;
            end
        end
    end

`ifdef CAN_FRAME_RX_EXT_ID_EN
    // extended-frame flag follows the other fields
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Rx_Ext <= 1'b0;
        end else if (dv_s) begin
            o_Rx_Ext <= ext_r;
        end else begin
            o_Rx_Ext <= o_Rx_Ext;
        end
    end
`else
    assign o_Rx_Ext = 1'b0;
`endif
endmodule
